// File: rtl/seq_divider_if.sv
// Request/result bundle between the control unit and the sequential divider.
// Carries the Start handshake with its operands and the Busy/Done status with results.
// Widths follow the WIDTH parameter, which must match the attached divider.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic             Signed_mode;
    logic [WIDTH-1:0] Dividend_in;
    logic [WIDTH-1:0] Divisor_in;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Quotient_out;
    logic [WIDTH-1:0] Remainder_out;
    logic             Div_by_zero;

    // Requester side (control unit / testbench)
    modport master (
        output Start, Signed_mode, Dividend_in, Divisor_in,
        input  Busy, Done, Quotient_out, Remainder_out, Div_by_zero
    );

    // Divider side
    modport slave (
        input  Start, Signed_mode, Dividend_in, Divisor_in,
        output Busy, Done, Quotient_out, Remainder_out, Div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock, unsigned or two's-complement signed.
// Latency: Done pulses WIDTH+1 edges after the accepting edge; divide-by-zero after 1 edge.
// Backpressure: Start is only sampled while Busy is low; requests during Busy are dropped.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          Reset,
    seq_divider_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder (always < divisor)
    logic [WIDTH-1:0]   dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   dsr_q, dsr_d;     // divisor magnitude
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   quo_out_q, quo_out_d;
    logic [WIDTH-1:0]   rem_out_q, rem_out_d;
    logic               dz_out_q, dz_out_d;

    logic               dvd_neg, dsr_neg;
    logic [WIDTH-1:0]   dvd_abs, dsr_abs;
    logic [WIDTH:0]     step;             // {rem, next dividend bit}, one bit wider than rem

    // Next-state, datapath step and result formatting
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        dz_out_d  = dz_out_q;

        dvd_neg = bus.Signed_mode & bus.Dividend_in[WIDTH-1];
        dsr_neg = bus.Signed_mode & bus.Divisor_in[WIDTH-1];
        dvd_abs = dvd_neg ? -bus.Dividend_in : bus.Dividend_in;
        dsr_abs = dsr_neg ? -bus.Divisor_in  : bus.Divisor_in;
        step    = {rem_q, dvd_q[WIDTH-1]};

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    neg_quo_d = dvd_neg ^ dsr_neg;
                    neg_rem_d = dvd_neg;
                    dsr_d     = dsr_abs;
                    rem_d     = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    dz_out_d  = 1'b0;
                    if (bus.Divisor_in == '0) begin
                        // Keep the raw dividend: it is returned verbatim as the remainder.
                        dz_d    = 1'b1;
                        dvd_d   = bus.Dividend_in;
                        state_d = S_FIX;
                    end else begin
                        dz_d    = 1'b0;
                        dvd_d   = dvd_abs;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (step >= {1'b0, dsr_q}) begin
                    rem_d = WIDTH'(step - {1'b0, dsr_q});
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = step[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (dz_q) begin
                    quo_out_d = '1;
                    rem_out_d = dvd_q;
                    dz_out_d  = 1'b1;
                end else begin
                    // MIN / -1 needs no special case: -(MIN) wraps back to MIN.
                    quo_out_d = neg_quo_q ? -dvd_q : dvd_q;
                    rem_out_d = neg_rem_q ? -rem_q : rem_q;
                    dz_out_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dz_out_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dz_out_q  <= dz_out_d;
        end
    end

    assign bus.Busy          = busy_q;
    assign bus.Done          = done_q;
    assign bus.Quotient_out  = quo_out_q;
    assign bus.Remainder_out = rem_out_q;
    assign bus.Div_by_zero   = dz_out_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and lightly randomised bench for seq_divider at WIDTH=32 and WIDTH=8.
// Expected results and latencies are queued when a request is issued and popped on Done.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_seq_divider;
    logic clk = 1'b0;
    logic Reset;

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(32)) b32();
    seq_divider_if #(.WIDTH(8))  b8();

    seq_divider #(.WIDTH(32)) dut32 (.clk(clk), .Reset(Reset), .bus(b32));
    seq_divider #(.WIDTH(8))  dut8  (.clk(clk), .Reset(Reset), .bus(b8));

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb32[$];
    exp_t sb8[$];
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mq, mr, ra, rb;
    logic        mdz;
    int          extra;
    int          w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_q(input int wd);
        return (wd == 8) ? {24'h0, b8.Quotient_out} : b32.Quotient_out;
    endfunction
    function automatic logic [31:0] get_r(input int wd);
        return (wd == 8) ? {24'h0, b8.Remainder_out} : b32.Remainder_out;
    endfunction
    function automatic logic [31:0] get_busy(input int wd);
        return {31'h0, (wd == 8) ? b8.Busy : b32.Busy};
    endfunction
    function automatic logic [31:0] get_done(input int wd);
        return {31'h0, (wd == 8) ? b8.Done : b32.Done};
    endfunction
    function automatic logic [31:0] get_dz(input int wd);
        return {31'h0, (wd == 8) ? b8.Div_by_zero : b32.Div_by_zero};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int wd, input logic [31:0] q, input logic [31:0] r,
                        input logic dz, input int lat);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz; e.lat = lat;
        if (wd == 8) sb8.push_back(e);
        else         sb32.push_back(e);
    endtask

    // Present a request for one edge; on return the accepting edge has just passed.
    task automatic start(input int wd, input logic sm, input logic [31:0] a, input logic [31:0] b);
        if (wd == 8) begin
            b8.Start = 1'b1; b8.Signed_mode = sm; b8.Dividend_in = a[7:0]; b8.Divisor_in = b[7:0];
        end else begin
            b32.Start = 1'b1; b32.Signed_mode = sm; b32.Dividend_in = a; b32.Divisor_in = b;
        end
        tick();
        b8.Start  = 1'b0;
        b32.Start = 1'b0;
        chk("busy_after_start", get_busy(wd), 32'd1);
        chk("done_cleared_on_start", get_done(wd), 32'd0);
        chk("dz_cleared_on_start", get_dz(wd), 32'd0);
    endtask

    // Wait (bounded) for Done, then pop and compare the queued expectation.
    task automatic wait_done(input int wd, input int already, input string tag);
        int   n;
        exp_t e;
        n = already;
        while (get_done(wd) != 32'd1 && n < 200) begin
            tick();
            n++;
        end
        if (wd == 8) e = sb8.pop_front();
        else         e = sb32.pop_front();
        chk({tag, "_latency"}, n, e.lat);
        chk({tag, "_busy_at_done"}, get_busy(wd), 32'd0);
        chk({tag, "_quotient"}, get_q(wd), e.q);
        chk({tag, "_remainder"}, get_r(wd), e.r);
        chk({tag, "_div_by_zero"}, get_dz(wd), {31'h0, e.dz});
    endtask

    // Reference division at 32 bits using the simulator's 64-bit arithmetic.
    task automatic model32(input logic sm, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa, sb;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
        end else if (!sm) begin
            q = a / b; r = a % b; dz = 1'b0;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            dz = 1'b0;
        end
    endtask

    initial begin
        Reset = 1'b1;
        b32.Start = 1'b0; b32.Signed_mode = 1'b0; b32.Dividend_in = '0; b32.Divisor_in = '0;
        b8.Start  = 1'b0; b8.Signed_mode  = 1'b0; b8.Dividend_in  = '0; b8.Divisor_in  = '0;
        repeat (3) tick();

        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 32 : 8;
            chk("reset_busy", get_busy(w), 32'd0);
            chk("reset_done", get_done(w), 32'd0);
            chk("reset_quotient", get_q(w), 32'd0);
            chk("reset_remainder", get_r(w), 32'd0);
            chk("reset_dz", get_dz(w), 32'd0);
        end
        Reset = 1'b0;
        tick();

        // Basic unsigned divide and its latency
        push(32, 32'h0000_000E, 32'h0000_0002, 1'b0, 33);
        start(32, 1'b0, 32'd100, 32'd7);
        wait_done(32, 0, "u100_7");

        // Signed -7/2, issued in the Done cycle of the previous divide
        push(32, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
        start(32, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(32, 0, "s_m7_2");

        push(32, 32'hFFFF_FFFF, 32'h0, 1'b0, 33);
        start(32, 1'b0, 32'hFFFF_FFFF, 32'h1);
        wait_done(32, 0, "u_max_1");

        // Divide by zero in both modes, then a normal divide must clear the flag
        push(32, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1);
        start(32, 1'b0, 32'h0000_1234, 32'h0);
        wait_done(32, 0, "dz_unsigned");
        push(32, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1);
        start(32, 1'b1, 32'h0000_1234, 32'h0);
        wait_done(32, 0, "dz_signed");
        push(32, 32'h0000_000E, 32'h0000_0002, 1'b0, 33);
        start(32, 1'b0, 32'd100, 32'd7);
        wait_done(32, 0, "after_dz");

        // Signed overflow MIN / -1
        push(32, 32'h8000_0000, 32'h0, 1'b0, 33);
        start(32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(32, 0, "s_overflow");

        // Second Start while busy must be ignored
        push(32, 32'd333, 32'd1, 1'b0, 33);
        start(32, 1'b0, 32'd1000, 32'd3);
        repeat (9) tick();
        b32.Start = 1'b1; b32.Dividend_in = 32'd55; b32.Divisor_in = 32'd5;
        tick();
        b32.Start = 1'b0;
        wait_done(32, 10, "busy_ignored");
        extra = 0;
        repeat (40) begin
            tick();
            if (b32.Done) extra++;
        end
        chk("single_done_pulse", extra, 32'd0);
        chk("held_quotient", b32.Quotient_out, 32'd333);

        // Reset in the middle of a divide aborts it
        start(32, 1'b1, 32'hFFFF_F000, 32'h0000_0010);
        repeat (14) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("abort_busy", get_busy(32), 32'd0);
        chk("abort_done", get_done(32), 32'd0);
        chk("abort_quotient", get_q(32), 32'd0);
        chk("abort_remainder", get_r(32), 32'd0);
        chk("abort_dz", get_dz(32), 32'd0);
        extra = 0;
        repeat (40) begin
            tick();
            if (b32.Done) extra++;
        end
        chk("abort_no_done", extra, 32'd0);
        push(32, 32'h0000_000E, 32'h0000_0002, 1'b0, 33);
        start(32, 1'b0, 32'd100, 32'd7);
        wait_done(32, 0, "after_abort");

        // Random operands against the reference model
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            model32(i[0], ra, rb, mq, mr, mdz);
            push(32, mq, mr, mdz, mdz ? 1 : 33);
            start(32, i[0], ra, rb);
            wait_done(32, 0, "random");
        end

        // Narrow instance
        push(8, 32'h0E, 32'h02, 1'b0, 9);
        start(8, 1'b0, 32'd100, 32'd7);
        wait_done(8, 0, "w8_u100_7");
        push(8, 32'hFD, 32'hFF, 1'b0, 9);
        start(8, 1'b1, 32'hF9, 32'h02);
        wait_done(8, 0, "w8_s_m7_2");
        push(8, 32'hFF, 32'h00, 1'b0, 9);
        start(8, 1'b0, 32'hFF, 32'h01);
        wait_done(8, 0, "w8_u_max_1");
        push(8, 32'hFF, 32'h5A, 1'b1, 1);
        start(8, 1'b1, 32'h5A, 32'h00);
        wait_done(8, 0, "w8_dz");
        push(8, 32'h80, 32'h00, 1'b0, 9);
        start(8, 1'b1, 32'h80, 32'hFF);
        wait_done(8, 0, "w8_s_overflow");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
